nasti_lite_script_seq: RTL and testbench

- Parametrised NASTI-lite (AXI-lite) master sequencer for bus-level test stimulus.
- Replaces hard-coded counter/case stimulus blocks that drive debug modules such as the UART DEM.
- Fetches command words from a parent-supplied lookup. Supported operations: write, read-and-check, poll-until-match with timeout, and end.
- Reports done/error status and the index of the failing command. Sits between a bench or SoC stimulus source and any NASTI-lite slave.

---
 rtl/nasti_lite_script_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_nasti_lite_script_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_lite_script_seq.sv
// NASTI-lite (AXI-lite) master sequencer that walks a command script supplied by
// the parent. Commands are {op, addr, data, mask}. The ops are WRITE, READ (checked
// against data under mask), POLL (re-read until a match or until the poll budget
// runs out) and END. The block reports a sticky done/error status together with
// the index of the command that failed.
`timescale 1ns/1ps

module nasti_lite_script_seq #(
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int DEPTH    = 32,
  parameter int POLL_MAX = 255,
  parameter int IW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [IW-1:0]          cmd_idx,
  input  logic [2+AW+2*DW-1:0]   cmd,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [IW-1:0]          err_idx,
  output logic [1:0]             err_code,
  output logic [AW-1:0]          aw_addr,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [DW-1:0]          w_data,
  output logic                   w_valid,
  input  logic                   w_ready,
  input  logic [1:0]             b_resp,
  input  logic                   b_valid,
  output logic                   b_ready,
  output logic [AW-1:0]          ar_addr,
  output logic                   ar_valid,
  input  logic                   ar_ready,
  input  logic [DW-1:0]          r_data,
  input  logic [1:0]             r_resp,
  input  logic                   r_valid,
  output logic                   r_ready
);

  localparam int CW  = 2 + AW + 2 * DW;
  localparam int PCW = $clog2(POLL_MAX + 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ERR_RESP  = 2'd1;
  localparam logic [1:0] ERR_MATCH = 2'd2;
  localparam logic [1:0] ERR_POLL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_FIN
  } state_t;

  state_t           state;
  logic             is_poll;
  logic [DW-1:0]    data_q;
  logic [DW-1:0]    mask_q;
  logic [PCW-1:0]   poll_cnt;

  // Fields of the command currently addressed by cmd_idx
  logic [1:0]       f_op;
  logic [AW-1:0]    f_addr;
  logic [DW-1:0]    f_data;
  logic [DW-1:0]    f_mask;
  logic             last_cmd;
  logic             rd_match;
  logic             aw_next;
  logic             w_next;

  assign f_op     = cmd[CW-1 -: 2];
  assign f_addr   = cmd[2*DW +: AW];
  assign f_data   = cmd[DW +: DW];
  assign f_mask   = cmd[0 +: DW];
  assign last_cmd = (cmd_idx == IW'(DEPTH - 1));
  assign rd_match = ((r_data & mask_q) == (data_q & mask_q));
  // Each write channel stays valid only until its own handshake
  assign aw_next  = aw_valid && !aw_ready;
  assign w_next   = w_valid && !w_ready;

  // Script sequencer: single registered FSM driving every bus and status output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_idx  <= '0;
      err_code <= 2'd0;
      aw_addr  <= '0;
      aw_valid <= 1'b0;
      w_data   <= '0;
      w_valid  <= 1'b0;
      b_ready  <= 1'b0;
      ar_addr  <= '0;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      is_poll  <= 1'b0;
      data_q   <= '0;
      mask_q   <= '0;
      poll_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          // Results hold here until a new start; busy is low so start is honoured
          if (start) begin
            state    <= S_FETCH;
            cmd_idx  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_idx  <= '0;
            err_code <= 2'd0;
          end
        end

        S_FETCH: begin
          case (f_op)
            OP_WRITE: begin
              aw_addr  <= f_addr;
              w_data   <= f_data;
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= S_WADDR;
            end
            OP_READ, OP_POLL: begin
              ar_addr  <= f_addr;
              ar_valid <= 1'b1;
              data_q   <= f_data;
              mask_q   <= f_mask;
              is_poll  <= (f_op == OP_POLL);
              poll_cnt <= '0;
              state    <= S_RADDR;
            end
            default: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end
          endcase
        end

        S_WADDR: begin
          aw_valid <= aw_next;
          w_valid  <= w_next;
          if (!aw_next && !w_next) begin
            b_ready <= 1'b1;
            state   <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (b_valid) begin
            b_ready <= 1'b0;
            if (b_resp != 2'b00) begin
              error    <= 1'b1;
              err_idx  <= cmd_idx;
              err_code <= ERR_RESP;
              busy     <= 1'b0;
              state    <= S_FIN;
            end else if (last_cmd) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              cmd_idx <= cmd_idx + 1'b1;
              state   <= S_FETCH;
            end
          end
        end

        S_RADDR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (r_valid) begin
            r_ready <= 1'b0;
            if (r_resp != 2'b00) begin
              error    <= 1'b1;
              err_idx  <= cmd_idx;
              err_code <= ERR_RESP;
              busy     <= 1'b0;
              state    <= S_FIN;
            end else if (rd_match) begin
              if (last_cmd) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_FIN;
              end else begin
                cmd_idx <= cmd_idx + 1'b1;
                state   <= S_FETCH;
              end
            end else if (!is_poll) begin
              error    <= 1'b1;
              err_idx  <= cmd_idx;
              err_code <= ERR_MATCH;
              busy     <= 1'b0;
              state    <= S_FIN;
            end else if ((poll_cnt + 1'b1) == PCW'(POLL_MAX)) begin
              // This read used up the last of the poll budget
              error    <= 1'b1;
              err_idx  <= cmd_idx;
              err_code <= ERR_POLL;
              busy     <= 1'b0;
              state    <= S_FIN;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              ar_valid <= 1'b1;
              state    <= S_RADDR;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nasti_lite_script_seq.sv
// Bench for nasti_lite_script_seq. A script array feeds cmd from cmd_idx and a
// small slave model answers the bus. Expected AW/W/AR beats are queued when a
// script is loaded, and a monitor pops and compares them on every handshake.
`timescale 1ns/1ps

module tb_nasti_lite_script_seq;

  localparam int AW       = 3;
  localparam int DW       = 8;
  localparam int DEPTH    = 32;
  localparam int POLL_MAX = 4;
  localparam int IW       = $clog2(DEPTH);
  localparam int CW       = 2 + AW + 2 * DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [IW-1:0] cmd_idx;
  logic [CW-1:0] cmd;
  logic          busy, done, error;
  logic [IW-1:0] err_idx;
  logic [1:0]    err_code;
  logic [AW-1:0] aw_addr;
  logic          aw_valid, aw_ready;
  logic [DW-1:0] w_data;
  logic          w_valid, w_ready;
  logic [1:0]    b_resp;
  logic          b_valid, b_ready;
  logic [AW-1:0] ar_addr;
  logic          ar_valid, ar_ready;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_valid, r_ready;

  logic [CW-1:0] script [DEPTH];
  assign cmd = script[cmd_idx];

  nasti_lite_script_seq #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx), .cmd(cmd),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx), .err_code(err_code),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [CW-1:0] mk(input logic [1:0] op, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d, input logic [DW-1:0] m);
    return {op, a, d, m};
  endfunction

  // Scoreboard queues and slave configuration
  logic [AW-1:0] exp_aw [$];
  logic [DW-1:0] exp_w  [$];
  logic [AW-1:0] exp_ar [$];
  logic [DW-1:0] rd_q   [$];
  int            b_count;
  int            slv_w_stall;
  logic [1:0]    slv_b_resp;
  logic [1:0]    slv_r_resp;
  logic          slv_ar_hold;

  // Slave model: samples handshakes before the edge, updates its outputs after it
  initial begin
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got;
    aw_ready = 1'b1; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b1; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
    aw_got = 1'b0; w_got = 1'b0;
    forever begin
      @(negedge clk);
      hs_aw = aw_valid && aw_ready;
      hs_w  = w_valid && w_ready;
      hs_b  = b_valid && b_ready;
      hs_ar = ar_valid && ar_ready;
      hs_r  = r_valid && r_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        aw_got = 1'b0; w_got = 1'b0; b_valid = 1'b0; r_valid = 1'b0;
        w_ready = 1'b1; ar_ready = !slv_ar_hold;
      end else begin
        if (hs_b) b_valid = 1'b0;
        if (hs_aw) aw_got = 1'b1;
        if (hs_w) w_got = 1'b1;
        if (aw_got && w_got) begin
          b_valid = 1'b1; b_resp = slv_b_resp; aw_got = 1'b0; w_got = 1'b0;
        end
        if (hs_r) r_valid = 1'b0;
        if (hs_ar) begin
          r_valid = 1'b1;
          r_resp  = slv_r_resp;
          if (rd_q.size() != 0) r_data = rd_q.pop_front();
          else r_data = '0;
        end
        ar_ready = !slv_ar_hold;
        if (w_valid && slv_w_stall > 0) begin
          w_ready = 1'b0;
          slv_w_stall--;
        end else begin
          w_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks valid/payload hold
  initial begin
    logic aw_pend, w_pend, ar_pend;
    logic [AW-1:0] aw_hold, ar_hold;
    logic [DW-1:0] w_hold;
    aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    aw_hold = '0; ar_hold = '0; w_hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
      end else begin
        if (aw_pend) begin
          chk("aw_valid_held", aw_valid, 1);
          chk("aw_addr_stable", aw_addr, aw_hold);
        end
        if (w_pend) begin
          chk("w_valid_held", w_valid, 1);
          chk("w_data_stable", w_data, w_hold);
        end
        if (ar_pend) begin
          chk("ar_valid_held", ar_valid, 1);
          chk("ar_addr_stable", ar_addr, ar_hold);
        end
        if (aw_valid && aw_ready) begin
          if (exp_aw.size() == 0) begin
            checks++; failures++;
            $display("FAIL aw_extra_beat actual=%0h required=none", aw_addr);
          end else chk("aw_addr", aw_addr, exp_aw.pop_front());
        end
        if (w_valid && w_ready) begin
          if (exp_w.size() == 0) begin
            checks++; failures++;
            $display("FAIL w_extra_beat actual=%0h required=none", w_data);
          end else chk("w_data", w_data, exp_w.pop_front());
        end
        if (ar_valid && ar_ready) begin
          if (exp_ar.size() == 0) begin
            checks++; failures++;
            $display("FAIL ar_extra_beat actual=%0h required=none", ar_addr);
          end else chk("ar_addr", ar_addr, exp_ar.pop_front());
        end
        if (b_valid && b_ready) b_count++;
        aw_pend = aw_valid && !aw_ready; aw_hold = aw_addr;
        w_pend  = w_valid && !w_ready;   w_hold  = w_data;
        ar_pend = ar_valid && !ar_ready; ar_hold = ar_addr;
      end
    end
  end

  task automatic clear_script();
    for (int i = 0; i < DEPTH; i++) script[i] = mk(2'b11, '0, '0, '0);
    b_count = 0;
  endtask

  // Pulse start and count cycles until busy falls, bounded
  task automatic run(input string tag, output int cyc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (busy && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) chk({tag, "_timeout_busy"}, busy, 0);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_aw_left"}, exp_aw.size(), 0);
    chk({tag, "_w_left"},  exp_w.size(),  0);
    chk({tag, "_ar_left"}, exp_ar.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0;
    slv_w_stall = 0; slv_b_resp = 2'b00; slv_r_resp = 2'b00; slv_ar_hold = 1'b0;
    clear_script();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_error", error, 0);       chk("rst_cmd_idx", cmd_idx, 0);
    chk("rst_err_idx", err_idx, 0);   chk("rst_err_code", err_code, 0);
    chk("rst_aw_valid", aw_valid, 0); chk("rst_w_valid", w_valid, 0);
    chk("rst_ar_valid", ar_valid, 0); chk("rst_b_ready", b_ready, 0);
    chk("rst_r_ready", r_ready, 0);   chk("rst_aw_addr", aw_addr, 0);
    chk("rst_w_data", w_data, 0);     chk("rst_ar_addr", ar_addr, 0);

    // UART divisor script, zero-wait slave
    clear_script();
    script[0] = mk(2'b00, 3'd3, 8'h80, 8'h00);
    script[1] = mk(2'b00, 3'd0, 8'hde, 8'h00);
    script[2] = mk(2'b00, 3'd0, 8'had, 8'h00);
    script[3] = mk(2'b00, 3'd3, 8'h00, 8'h00);
    exp_aw = '{3'd3, 3'd0, 3'd0, 3'd3};
    exp_w  = '{8'h80, 8'hde, 8'had, 8'h00};
    run("uart", cyc);
    chk("uart_cycles", cyc, 13);
    chk("uart_done", done, 1);
    chk("uart_error", error, 0);
    chk("uart_b_count", b_count, 4);
    drained("uart");

    // READ that matches under mask
    clear_script();
    script[0] = mk(2'b01, 3'd5, 8'h20, 8'h20);
    rd_q = '{8'h60};
    exp_ar = '{3'd5};
    run("read_ok", cyc);
    chk("read_ok_cycles", cyc, 4);
    chk("read_ok_done", done, 1);
    chk("read_ok_error", error, 0);
    drained("read_ok");

    // Same READ, mismatch
    rd_q = '{8'h00};
    exp_ar = '{3'd5};
    run("read_bad", cyc);
    chk("read_bad_cycles", cyc, 3);
    chk("read_bad_error", error, 1);
    chk("read_bad_done", done, 0);
    chk("read_bad_code", err_code, 2);
    chk("read_bad_idx", err_idx, 0);
    drained("read_bad");

    // POLL that matches on the third read, then a WRITE
    clear_script();
    script[0] = mk(2'b10, 3'd5, 8'h20, 8'h20);
    script[1] = mk(2'b00, 3'd1, 8'h5a, 8'h00);
    rd_q = '{8'h00, 8'h00, 8'h20};
    exp_ar = '{3'd5, 3'd5, 3'd5};
    exp_aw = '{3'd1};
    exp_w  = '{8'h5a};
    run("poll_ok", cyc);
    chk("poll_ok_cycles", cyc, 11);
    chk("poll_ok_done", done, 1);
    chk("poll_ok_error", error, 0);
    drained("poll_ok");

    // POLL that never matches: POLL_MAX reads then timeout
    clear_script();
    script[0] = mk(2'b00, 3'd2, 8'h11, 8'h00);
    script[1] = mk(2'b10, 3'd5, 8'h20, 8'h20);
    exp_aw = '{3'd2};
    exp_w  = '{8'h11};
    exp_ar = '{3'd5, 3'd5, 3'd5, 3'd5};
    run("poll_to", cyc);
    chk("poll_to_cycles", cyc, 12);
    chk("poll_to_error", error, 1);
    chk("poll_to_done", done, 0);
    chk("poll_to_code", err_code, 3);
    chk("poll_to_idx", err_idx, 1);
    drained("poll_to");

    // Stalled W channel, then an error write response
    clear_script();
    script[0] = mk(2'b00, 3'd6, 8'hc3, 8'h00);
    exp_aw = '{3'd6};
    exp_w  = '{8'hc3};
    slv_w_stall = 5;
    slv_b_resp  = 2'b10;
    run("wstall", cyc);
    slv_b_resp  = 2'b00;
    chk("wstall_cycles", cyc, 8);
    chk("wstall_error", error, 1);
    chk("wstall_code", err_code, 1);
    chk("wstall_idx", err_idx, 0);
    chk("wstall_b_count", b_count, 1);
    drained("wstall");

    // Full-length script of writes, no END
    clear_script();
    for (int i = 0; i < DEPTH; i++) begin
      script[i] = mk(2'b00, AW'(i), DW'(i * 3 + 1), 8'h00);
      exp_aw.push_back(AW'(i));
      exp_w.push_back(DW'(i * 3 + 1));
    end
    run("full", cyc);
    chk("full_cycles", cyc, 3 * DEPTH);
    chk("full_done", done, 1);
    chk("full_error", error, 0);
    chk("full_cmd_idx", cmd_idx, DEPTH - 1);
    chk("full_b_count", b_count, DEPTH);
    drained("full");

    // Reset while an AR is outstanding, then a fresh run from index 0
    clear_script();
    script[0] = mk(2'b00, 3'd4, 8'h77, 8'h00);
    script[1] = mk(2'b01, 3'd5, 8'h20, 8'h20);
    exp_aw = '{3'd4};
    exp_w  = '{8'h77};
    slv_ar_hold = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(ar_valid && cmd_idx == IW'(1)) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_ar_valid", ar_valid, 1);
    chk("mid_cmd_idx", cmd_idx, 1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_ar_valid", ar_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_idx", cmd_idx, 0);
    slv_ar_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    drained("mid_rst");
    b_count = 0;
    exp_aw = '{3'd4};
    exp_w  = '{8'h77};
    exp_ar = '{3'd5};
    rd_q   = '{8'h20};
    run("rerun", cyc);
    chk("rerun_cycles", cyc, 7);
    chk("rerun_done", done, 1);
    chk("rerun_error", error, 0);
    chk("rerun_b_count", b_count, 1);
    drained("rerun");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
